// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rstseq_pkg
// Shared definitions for the reset sequencer: FSM state encoding and the
// width of the debounce-abort (glitch) counter.
// -----------------------------------------------------------------------------
package rstseq_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } seq_state_e;

    localparam int GLITCH_W = 8;

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the request input and the sequenced outputs of reset_sequencer.
//   req_i        : asynchronous request level (1 = bring system up)
//   stage_o      : thermometer of released stages
//   done_o       : all stages released
//   busy_o       : sequencing up or down in progress
//   glitch_cnt_o : aborted-debounce count (0 when the counter is built out)
// master = request source / observer, slave = the sequencer.
// -----------------------------------------------------------------------------
interface reset_sequencer_if
    import rstseq_pkg::*;
#(
    parameter int NSTAGE = 4
);
    logic                req_i;
    logic [NSTAGE-1:0]   stage_o;
    logic                done_o;
    logic                busy_o;
    logic [GLITCH_W-1:0] glitch_cnt_o;

    modport master (
        output req_i,
        input  stage_o,
        input  done_o,
        input  busy_o,
        input  glitch_cnt_o
    );

    modport slave (
        input  req_i,
        output stage_o,
        output done_o,
        output busy_o,
        output glitch_cnt_o
    );
endinterface

// File: rtl/reset_sequencer_sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// Synchroniser chain followed by a debounce filter.
//   clk_i    : system clock
//   rst_i    : synchronous active-low reset
//   d_i      : asynchronous input level
//   q_o      : debounced level (req_f); follows the synchronised level once it
//              has differed for DEBOUNCE consecutive edges
//   glitch_o : one-cycle pulse when the synchronised level returns to q_o
//              before the debounce count completed
// SYNC_STAGES = 0 passes d_i straight to the debouncer.
// -----------------------------------------------------------------------------
module sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic glitch_o
);

    localparam int            DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic            req_s;
    logic            req_f_q, req_f_d;
    logic [DB_W-1:0] db_q, db_d;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign req_s = d_i;
    end else begin : g_sync
        // bit 0 is the first flop of the chain
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
            end
        end

        assign req_s = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        req_f_d = req_f_q;
        db_d    = db_q;
        if (req_s == req_f_q) begin
            db_d = '0;
        end else if (db_q == DB_LAST) begin
            req_f_d = req_s;
            db_d    = '0;
        end else begin
            db_d = db_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            req_f_q <= 1'b0;
            db_q    <= '0;
        end else begin
            req_f_q <= req_f_d;
            db_q    <= db_d;
        end
    end

    assign q_o      = req_f_q;
    assign glitch_o = (req_s == req_f_q) && (db_q != '0);

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Debounces a reset/lock request and releases NSTAGE ordered enables as a
// thermometer, one stage every STAGE_DLY cycles; removal withdraws them in
// reverse order, or all at once when FAST_OFF = 1.
//   clk_i  : system clock
//   rst_i  : synchronous active-low reset
//   seq_if : reset_sequencer_if.slave (req_i, stage_o, done_o, busy_o,
//            glitch_cnt_o)
// Build option: define RSTSEQ_GLITCH_CNT_EN to include the 8-bit saturating
// count of aborted debounces; otherwise glitch_cnt_o is tied to 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// OFF   | all stages held, waiting for debounced request
// UP    | raising one stage per STAGE_DLY cycles
// ON    | all stages released
// DOWN  | dropping one stage per STAGE_DLY cycles, highest first
// -----------------------------------------------------------------------------
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int NSTAGE      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16,
    parameter int STAGE_DLY   = 1024,
    parameter int FAST_OFF    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reset_sequencer_if.slave  seq_if
);

    localparam int              ST_W    = $clog2(STAGE_DLY + 1);
    localparam int              LVL_W   = $clog2(NSTAGE + 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STAGE_DLY - 1);
    localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(NSTAGE);

    logic              req_f;
    logic              glitch;
    seq_state_e        state_q;
    logic [ST_W-1:0]   st_q;
    logic [LVL_W-1:0]  lvl_q;
    logic [NSTAGE-1:0] stage_q;
    logic              done_q;
    logic              busy_q;

    sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) u_sync_debounce (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .d_i      (seq_if.req_i),
        .q_o      (req_f),
        .glitch_o (glitch)
    );

    // Stages are shifted in/out at the low end so stage_q stays a thermometer
    // without indexing by lvl_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_OFF;
            st_q    <= '0;
            lvl_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (req_f) begin
                        state_q <= S_UP;
                        st_q    <= '0;
                        lvl_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_UP: begin
                    if (!req_f) begin
                        st_q <= '0;
                        if ((FAST_OFF != 0) || (lvl_q == '0)) begin
                            state_q <= S_OFF;
                            stage_q <= '0;
                            lvl_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DOWN;
                        end
                    end else if (st_q == ST_LAST) begin
                        stage_q <= (stage_q << 1) | NSTAGE'(1);
                        lvl_q   <= lvl_q + LVL_W'(1);
                        st_q    <= '0;
                        if (lvl_q == LVL_TOP - LVL_W'(1)) begin
                            state_q <= S_ON;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        st_q <= st_q + ST_W'(1);
                    end
                end

                S_ON: begin
                    if (!req_f) begin
                        done_q <= 1'b0;
                        st_q   <= '0;
                        if (FAST_OFF != 0) begin
                            state_q <= S_OFF;
                            stage_q <= '0;
                            lvl_q   <= '0;
                        end else begin
                            state_q <= S_DOWN;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                S_DOWN: begin
                    if (req_f) begin
                        st_q <= '0;
                        // nothing has been dropped yet: go straight back to ON
                        if (lvl_q == LVL_TOP) begin
                            state_q <= S_ON;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_UP;
                        end
                    end else if (st_q == ST_LAST) begin
                        stage_q <= stage_q >> 1;
                        lvl_q   <= lvl_q - LVL_W'(1);
                        st_q    <= '0;
                        if (lvl_q == LVL_W'(1)) begin
                            state_q <= S_OFF;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        st_q <= st_q + ST_W'(1);
                    end
                end

                default: begin
                    state_q <= S_OFF;
                    st_q    <= '0;
                    lvl_q   <= '0;
                    stage_q <= '0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.stage_o = stage_q;
    assign seq_if.done_o  = done_q;
    assign seq_if.busy_o  = busy_q;

`ifdef RSTSEQ_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            glitch_cnt_q <= '0;
        end else if (glitch && (glitch_cnt_q != '1)) begin
            glitch_cnt_q <= glitch_cnt_q + GLITCH_W'(1);
        end
    end

    assign seq_if.glitch_cnt_o = glitch_cnt_q;
`else
    logic glitch_unused;
    assign glitch_unused       = glitch;
    assign seq_if.glitch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int NST = 4;
    localparam int SYN = 2;
    localparam int DEB = 4;
    localparam int DLY = 3;
`ifdef RSTSEQ_GLITCH_CNT_EN
    localparam int GL_ON = 1;
`else
    localparam int GL_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic req   = 1'b0;

    reset_sequencer_if #(.NSTAGE(NST)) if_s ();
    reset_sequencer_if #(.NSTAGE(NST)) if_f ();
    assign if_s.req_i = req;
    assign if_f.req_i = req;

    reset_sequencer #(
        .NSTAGE(NST), .SYNC_STAGES(SYN), .DEBOUNCE(DEB), .STAGE_DLY(DLY), .FAST_OFF(0)
    ) dut_s (
        .clk_i(clk), .rst_i(rst_n), .seq_if(if_s)
    );

    reset_sequencer #(
        .NSTAGE(NST), .SYNC_STAGES(SYN), .DEBOUNCE(DEB), .STAGE_DLY(DLY), .FAST_OFF(1)
    ) dut_f (
        .clk_i(clk), .rst_i(rst_n), .seq_if(if_f)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Front end: req delayed by SYN edges; debounced level flips once the
    // synchronised level has disagreed with it for DEB consecutive edges.
    // Sequencer: integer level plus direction (+1 rising, -1 falling, 0 idle)
    // and edges left until the next stage step. Index 0 = slow off, 1 = fast off.
    int pipe [SYN];
    int hist [$];
    int rf_m;
    int gl_m;
    int lvl_m  [2];
    int dir_m  [2];
    int left_m [2];
    bit started = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYN; i++) pipe[i] = 0;
            hist.delete();
            rf_m = 0;
            gl_m = 0;
            for (int k = 0; k < 2; k++) begin
                lvl_m[k] = 0; dir_m[k] = 0; left_m[k] = 0;
            end
        end else begin
            int rs;
            int streak;
            for (int k = 0; k < 2; k++) begin
                bit fast;
                fast = (k == 1);
                if (dir_m[k] == 0) begin
                    if (lvl_m[k] == 0 && rf_m == 1) begin
                        dir_m[k] = 1; left_m[k] = DLY;
                    end else if (lvl_m[k] == NST && rf_m == 0) begin
                        if (fast) lvl_m[k] = 0;
                        else begin dir_m[k] = -1; left_m[k] = DLY; end
                    end
                end else if (dir_m[k] == 1) begin
                    if (rf_m == 0) begin
                        if (fast) begin lvl_m[k] = 0; dir_m[k] = 0; end
                        else if (lvl_m[k] == 0) dir_m[k] = 0;
                        else begin dir_m[k] = -1; left_m[k] = DLY; end
                    end else begin
                        left_m[k]--;
                        if (left_m[k] == 0) begin
                            lvl_m[k]++; left_m[k] = DLY;
                            if (lvl_m[k] == NST) dir_m[k] = 0;
                        end
                    end
                end else begin
                    if (rf_m == 1) begin
                        dir_m[k] = (lvl_m[k] == NST) ? 0 : 1; left_m[k] = DLY;
                    end else begin
                        left_m[k]--;
                        if (left_m[k] == 0) begin
                            lvl_m[k]--; left_m[k] = DLY;
                            if (lvl_m[k] == 0) dir_m[k] = 0;
                        end
                    end
                end
            end
            rs = pipe[SYN-1];
            streak = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != rf_m) streak++;
                else break;
            end
            if (rs == rf_m) begin
                if (streak > 0 && gl_m < 255) gl_m++;
            end else if (streak + 1 >= DEB) begin
                rf_m = rs;
            end
            hist.push_back(rs);
            if (hist.size() > 32) void'(hist.pop_front());
            for (int i = SYN - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = int'(req);
        end
        started = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("m_stage_s", int'(if_s.stage_o), (1 << lvl_m[0]) - 1);
            chk("m_done_s",  int'(if_s.done_o),  int'(lvl_m[0] == NST && dir_m[0] == 0));
            chk("m_busy_s",  int'(if_s.busy_o),  int'(dir_m[0] != 0));
            chk("m_glitch_s", int'(if_s.glitch_cnt_o), GL_ON * gl_m);
            chk("m_stage_f", int'(if_f.stage_o), (1 << lvl_m[1]) - 1);
            chk("m_done_f",  int'(if_f.done_o),  int'(lvl_m[1] == NST && dir_m[1] == 0));
            chk("m_busy_f",  int'(if_f.busy_o),  int'(dir_m[1] != 0));
            chk("m_glitch_f", int'(if_f.glitch_cnt_o), GL_ON * gl_m);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        tick(3);
        chk("rst_stage", int'(if_s.stage_o), 0);
        chk("rst_done",  int'(if_s.done_o), 0);
        chk("rst_busy",  int'(if_s.busy_o), 0);
        chk("rst_glitch", int'(if_s.glitch_cnt_o), 0);

        // power-up: request present before edge 1
        rst_n = 1'b1;
        req   = 1'b1;
        tick(6);  chk("pu_busy_e6",  int'(if_s.busy_o), 0);
        tick(1);  chk("pu_busy_e7",  int'(if_s.busy_o), 1);
        tick(2);  chk("pu_stage_e9", int'(if_s.stage_o), 0);
        tick(1);  chk("pu_stage_e10", int'(if_s.stage_o), 1);
        tick(3);  chk("pu_stage_e13", int'(if_s.stage_o), 3);
        tick(3);  chk("pu_stage_e16", int'(if_s.stage_o), 7);
                  chk("pu_done_e16", int'(if_s.done_o), 0);
        tick(3);  chk("pu_stage_e19", int'(if_s.stage_o), 15);
                  chk("pu_done_e19", int'(if_s.done_o), 1);
                  chk("pu_busy_e19", int'(if_s.busy_o), 0);
                  chk("pu_stage_f_e19", int'(if_f.stage_o), 15);
        tick(5);

        // shutdown
        req = 1'b0;
        tick(6);  chk("sd_stage_f_e6", int'(if_f.stage_o), 15);
        tick(1);  chk("sd_stage_f_e7", int'(if_f.stage_o), 0);
                  chk("sd_done_f_e7",  int'(if_f.done_o), 0);
                  chk("sd_busy_s_e7",  int'(if_s.busy_o), 1);
                  chk("sd_stage_s_e7", int'(if_s.stage_o), 15);
        tick(3);  chk("sd_stage_s_e10", int'(if_s.stage_o), 7);
        tick(3);  chk("sd_stage_s_e13", int'(if_s.stage_o), 3);
        tick(6);  chk("sd_stage_s_e19", int'(if_s.stage_o), 0);
                  chk("sd_busy_s_e19",  int'(if_s.busy_o), 0);
        tick(5);

        // 3-cycle glitch, shorter than the debounce window
        req = 1'b1;
        tick(3);
        req = 1'b0;
        tick(20);
        chk("gl_stage_s", int'(if_s.stage_o), 0);
        chk("gl_stage_f", int'(if_f.stage_o), 0);
        chk("gl_count",   int'(if_s.glitch_cnt_o), GL_ON);

        // reversal: drop so DOWN starts at 0011, return while at 0001
        req = 1'b1;
        tick(8);
        req = 1'b0;
        tick(5);  chk("rv_stage_e13", int'(if_s.stage_o), 3);
        req = 1'b1;
        tick(2);  chk("rv_stage_e15", int'(if_s.stage_o), 3);
                  chk("rv_busy_e15",  int'(if_s.busy_o), 1);
                  chk("rv_stage_f_e15", int'(if_f.stage_o), 0);
        tick(3);  chk("rv_stage_e18", int'(if_s.stage_o), 1);
        tick(4);  chk("rv_stage_e22", int'(if_s.stage_o), 1);
        tick(1);  chk("rv_stage_e23", int'(if_s.stage_o), 3);
                  chk("rv_stage_f_e23", int'(if_f.stage_o), 1);
        tick(6);  chk("rv_stage_e29", int'(if_s.stage_o), 15);
                  chk("rv_done_e29",  int'(if_s.done_o), 1);
                  chk("rv_stage_f_e29", int'(if_f.stage_o), 7);
        tick(5);

        // reset mid-sequence
        req = 1'b0;
        tick(25);
        req = 1'b1;
        tick(13); chk("mr_stage_pre", int'(if_s.stage_o), 3);
        rst_n = 1'b0;
        tick(1);  chk("mr_stage",  int'(if_s.stage_o), 0);
                  chk("mr_busy",   int'(if_s.busy_o), 0);
                  chk("mr_done",   int'(if_s.done_o), 0);
                  chk("mr_glitch", int'(if_s.glitch_cnt_o), 0);
                  chk("mr_stage_f", int'(if_f.stage_o), 0);
        rst_n = 1'b1;
        tick(9);  chk("mr_stage_e9",  int'(if_s.stage_o), 0);
        tick(1);  chk("mr_stage_e10", int'(if_s.stage_o), 1);
        tick(9);  chk("mr_stage_e19", int'(if_s.stage_o), 15);
                  chk("mr_done_e19",  int'(if_s.done_o), 1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised successor to the single-output reset delay. Takes one asynchronous request level (button, PLL lock or a combination), synchronises and debounces it, then releases NSTAGE ordered enables/reset-releases as a thermometer, one stage every STAGE_DLY cycles. Request removal withdraws them in reverse order, or all at once if FAST_OFF is set. Sits between the board reset/lock sources and the CPU, memory and peripheral resets on the SoC top.

Parameters:
NSTAGE, 4, number of sequenced outputs (1..16)
SYNC_STAGES, 2, synchroniser flops on req_i (0 = input already synchronous)
DEBOUNCE, 16, cycles req_s must differ from req_f before req_f follows (>=1)
STAGE_DLY, 1024, cycles between consecutive stage transitions (>=1)
FAST_OFF, 0, 1 = all stages drop together on request removal

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-low reset
req_i  in  1  asynchronous request level; 1 = bring system up
stage_o  out  NSTAGE  thermometer enables; bit k = stage k released
done_o  out  1  all stages released (state ON)
busy_o  out  1  sequencing in progress (state UP or DOWN)
glitch_cnt_o  out  8  debounce-abort count (see Optional Feature)

Behaviour:
- Reset (rst_i=0 at a clk_i edge): sync flops, req_f, all counters and stage_o = 0; state OFF; done_o=0, busy_o=0; glitch_cnt_o=0. Reset mid-sequence drops every stage on that edge.
- Synchroniser: SYNC_STAGES flop chain gives req_s.
- Debounce: if req_s==req_f, db_ctr<=0. Otherwise db_ctr increments. When db_ctr==DEBOUNCE-1, req_f<=req_s and db_ctr<=0.
- Counter widths: db_ctr is $clog2(DEBOUNCE+1); st_ctr is $clog2(STAGE_DLY+1); lvl is $clog2(NSTAGE+1).
- FSM, with st_ctr counting 0..STAGE_DLY-1:
  - OFF: req_f=1 -> UP, st_ctr=0, lvl=0.
  - UP: st_ctr++. At st_ctr==STAGE_DLY-1: stage_o[lvl]<=1, lvl++, st_ctr<=0. lvl reaching NSTAGE -> ON.
  - ON: req_f=0 -> DOWN, st_ctr=0. With FAST_OFF=1: -> OFF, stage_o<=0 on the same edge.
  - DOWN: st_ctr++. At STAGE_DLY-1: stage_o[lvl-1]<=0, lvl--. lvl reaching 0 -> OFF.
- Reversals:
  - UP with req_f=0: -> DOWN with st_ctr=0, keeping raised stages; -> OFF if lvl==0. FAST_OFF -> OFF with all stages cleared.
  - DOWN with req_f=1: -> UP with st_ctr=0, keeping remaining stages.
- Invariant: stage_o is always a thermometer (bit k set implies bit k-1 set). Only one stage changes per transition, except the FAST_OFF collapse.
- Latency: with req_i changed before edge 1, req_f updates at edge SYNC_STAGES+DEBOUNCE. stage_o[0] rises at edge SYNC_STAGES+DEBOUNCE+1+STAGE_DLY. Each later stage rises STAGE_DLY edges after the previous one.
- Outputs: done_o = (state==ON); busy_o = (state==UP | state==DOWN). Both are registered and change on the same edge as the state.

Optional Feature:
RSTSEQ_GLITCH_CNT_EN
- Defined: glitch_cnt_o is an 8-bit saturating counter. It increments whenever req_s returns to req_f while db_ctr!=0 (an aborted debounce). It holds at 255 and is cleared only by reset.
- Undefined: counter logic is absent and glitch_cnt_o is tied to 0. All other behaviour is identical.

Decomposition:
- Package rstseq_pkg:
  - state encoding OFF=2'd0, UP=2'd1, ON=2'd2, DOWN=2'd3
  - glitch counter width constant (8)
- Sub-module sync_debounce (params SYNC_STAGES, DEBOUNCE; ports clk_i, rst_i, d_i, q_o, glitch_o) holds the synchroniser, debounce and glitch pulse. The sequencer FSM stays in reset_sequencer.

Test Plan:
- Power-up: NSTAGE=4, SYNC_STAGES=2, DEBOUNCE=4, STAGE_DLY=3, req_i 0->1 before edge 1 -> stage_o 0001 at edge 10, 0011 at 13, 0111 at 16, 1111 at 19; done_o=1 at edge 19; busy_o high on edges 7..18.
- Orderly shutdown: from ON, req_i 1->0 -> stage_o 0111, 0011, 0001, 0000 at 3-cycle spacing, starting at edge SYNC+DEBOUNCE+1+3 after the change; final state OFF, busy_o=0.
- Glitch rejection: DEBOUNCE=4, 3-cycle req_i pulse -> stage_o stays 0000. With RSTSEQ_GLITCH_CNT_EN, glitch_cnt_o=1.
- Reversal: req_i falls while stage_o=0011 in UP -> DOWN; 0001 then 0000. req_i rises again at 0001 -> UP resumes from 0001.
- FAST_OFF=1: from ON, req_f falls -> stage_o 1111->0000 in one edge; state OFF.
- Reset mid-sequence: rst_i=0 for one edge while stage_o=0011 -> all outputs 0 on that edge; after release with req_i=1, full power-up latency repeats.
